ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Hardwired control unit that drives the bus datapath through fetch (T0–T2) and register-register ALU execute (T3–T6).
- Produces every out/in strobe the datapath consumes, plus one-hot register enables decoded from IR fields.
- Replaces hand-sequenced strobes with a Moore FSM clocked by the datapath clock.

Parameters:
- ALU_OP_W, 5, width of opcode field and alu_op output
- NUM_REGS, 16, general registers; width of reg_in/reg_out
- IR_W, 32, instruction register width

Ports:
- Clock  in  1  system clock, rising edge
- Clear  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary
- mem_rdy  in  1  memory read data valid on Mdatain
- IR  in  IR_W  datapath instruction register contents
- PCout, MDRout, Zhighout, Zlowout  out  1 each  bus drive strobes
- PCin, IncPC, MARin, MDRin, IRin, Yin  out  1 each  register load strobes
- Read  out  1  memory read strobe
- ZHighIn, ZLowIn, HIin, LOin  out  1 each  Z/HI/LO load strobes
- alu_op  out  ALU_OP_W  operation select to ALU
- reg_out  out  NUM_REGS  one-hot general register bus drive
- reg_in  out  NUM_REGS  one-hot general register load
- halted  out  1  high in HALT state
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- IR fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Opcodes:
  - 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl — binary ops
  - 01111 mul, 10000 div — binary, 64-bit result to HI/LO
  - 10001 neg, 10010 not — unary, source Rb
  - 11010 nop, 11011 halt
  - all other codes illegal
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are a pure function of state and registered IR; no output depends combinationally on run/mem_rdy.
- Reset (Clear=1, any time, async): state←IDLE. All outputs 0, alu_op=0, reg_in/reg_out=0, halted=0, illegal=0. Strobes drop in the same cycle Clear rises.
- IDLE: all outputs 0. Goes to T0 when run=1.
- T0: PCout, MARin, IncPC, PCin. PC increments in place. Next state is T1.
- T1: Read, MDRin. Stays in T1 while mem_rdy=0; both strobes stay asserted throughout. Goes to T2 on mem_rdy=1.
- T2: MDRout, IRin. IR is valid from T3 onward. Next state:
  - nop → boundary
  - halt → HALT
  - unary → T4
  - illegal → boundary, with illegal=1 for this cycle
  - otherwise → T3
- T3: reg_out[Rb], Yin.
- T4: reg_out[Rc] for binary ops, reg_out[Rb] for unary ops; alu_op=op; ZLowIn. ZHighIn is also asserted for mul/div.
- T5: Zlowout. Loads reg_in[Ra] for most ops; loads LOin instead for mul/div. Next state: mul/div → T6, otherwise → boundary.
- T6 (mul/div only): Zhighout, HIin. Next state is boundary.
- Boundary: goes to T0 if run=1, else IDLE.
- Latency per instruction, assuming mem_rdy=1 in the first T1 cycle:
  - 6 cycles for binary ops
  - 5 cycles for unary ops
  - 7 cycles for mul/div
  - 3 cycles for nop
  - each mem_rdy=0 cycle in T1 adds one cycle
- reg_in/reg_out are exactly one-hot or zero. Writes to R0 are allowed.
- alu_op is 0 outside T4.
- HALT: halted=1, all strobes 0. Exits only via Clear; run is ignored.
- run falling mid-instruction does not abort the instruction; it completes.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - adds output instr_count [31:0]
  - counter increments by 1 at each boundary transition from T2 (nop), T5 (non-mul/div) or T6
  - illegal and halt do not count
  - cleared by Clear; wraps 0xFFFFFFFF→0
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package `ctrl_pkg`: state encoding constants, opcode constants (OP_ADD…OP_HALT), IR field bit positions.
- Sub-module `reg_sel_decode`: 4-bit register index to NUM_REGS one-hot, with an enable input. Instantiated twice, once for reg_in and once for reg_out.

Test Plan:
- Clear, then run=1, mem_rdy=1, IR=0x28918000 (and R1,R2,R3) →
  - T3: reg_out=16'h0004, Yin=1
  - T4: reg_out=16'h0008, alu_op=5'b00101, ZLowIn=1, ZHighIn=0
  - T5: Zlowout=1, reg_in=16'h0002
  - returns to T0 after 6 cycles
- IR=0x80228000 (div R4,R5) →
  - T3: reg_out=16'h0010
  - T4: reg_out=16'h0020, alu_op=5'b10000, ZLowIn=ZHighIn=1
  - T5: Zlowout, LOin
  - T6: Zhighout, HIin
  - reg_in stays 0 throughout
- mem_rdy held 0 for 3 cycles at T1 → Read=MDRin=1 for 4 consecutive cycles; IRin asserts in the following cycle.
- IR=0xF8000000 → illegal pulses exactly one cycle in T2; next state T0. With SEQ_PERF_CNT_EN, instr_count is unchanged.
- IR=0xD8000000 (halt) → halted=1 and stays high with run=1. Clear then returns to IDLE with halted=0.
- Clear asserted mid-T4 → all strobes 0 before the next Clock edge; after release with run=1, the first cycle shows PCout=MARin=IncPC=PCin=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// opcode values, IR field positions and opcode classification.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_BINARY,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT
    } op_class_t;

    localparam int OP_W      = 5;
    localparam int REG_IDX_W = 4;
    localparam int OP_LSB    = 27;
    localparam int RA_LSB    = 23;
    localparam int RB_LSB    = 19;
    localparam int RC_LSB    = 15;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: classify = CLS_BINARY;
            OP_MUL, OP_DIV:                                classify = CLS_MULDIV;
            OP_NEG, OP_NOT:                                classify = CLS_UNARY;
            OP_NOP:                                        classify = CLS_NOP;
            OP_HALT:                                       classify = CLS_HALT;
            default:                                       classify = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// Register index to one-hot select; output is all-zero when disabled or
// when the index is beyond the register file.
module reg_sel_decode #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Moore control FSM sequencing fetch (T0-T2) and register ALU execute (T3-T6).
// Optional instruction counter enabled by defining SEQ_PERF_CNT_EN.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 5,
    parameter int NUM_REGS = 16,
    parameter int IR_W     = 32
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                run,
    input  logic                mem_rdy,
    input  logic [IR_W-1:0]     IR,
    output logic                PCout,
    output logic                MDRout,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Read,
    output logic                ZHighIn,
    output logic                ZLowIn,
    output logic                HIin,
    output logic                LOin,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                halted,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]         instr_count,
`endif
    output logic                illegal
);

    state_t                 state, state_next;
    logic [OP_W-1:0]        op;
    logic [REG_IDX_W-1:0]   ra, rb, rc;
    op_class_t              cls;
    logic                   rout_en, rin_en;
    logic [REG_IDX_W-1:0]   rout_idx;
    state_t                 boundary;
    logic                   unused_ir;

    assign op        = IR[OP_LSB +: OP_W];
    assign ra        = IR[RA_LSB +: REG_IDX_W];
    assign rb        = IR[RB_LSB +: REG_IDX_W];
    assign rc        = IR[RC_LSB +: REG_IDX_W];
    assign cls       = classify(op);
    assign boundary  = run ? ST_T0 : ST_IDLE;
    assign unused_ir = ^IR;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        PCout      = 1'b0;
        MDRout     = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Read       = 1'b0;
        ZHighIn    = 1'b0;
        ZLowIn     = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        alu_op     = '0;
        halted     = 1'b0;
        illegal    = 1'b0;
        rout_en    = 1'b0;
        rin_en     = 1'b0;
        rout_idx   = rb;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_T0;
            end
            ST_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                PCin       = 1'b1;
                state_next = ST_T1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_rdy) state_next = ST_T2;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                case (cls)
                    CLS_NOP:   state_next = boundary;
                    CLS_HALT:  state_next = ST_HALT;
                    CLS_UNARY: state_next = ST_T4;
                    CLS_ILLEGAL: begin
                        illegal    = 1'b1;
                        state_next = boundary;
                    end
                    default:   state_next = ST_T3;
                endcase
            end
            ST_T3: begin
                rout_en    = 1'b1;
                Yin        = 1'b1;
                state_next = ST_T4;
            end
            ST_T4: begin
                // Unary ops skip T3, so their single source Rb is driven here.
                rout_en    = 1'b1;
                rout_idx   = (cls == CLS_UNARY) ? rb : rc;
                alu_op     = ALU_OP_W'(op);
                ZLowIn     = 1'b1;
                ZHighIn    = (cls == CLS_MULDIV);
                state_next = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (cls == CLS_MULDIV) begin
                    LOin       = 1'b1;
                    state_next = ST_T6;
                end else begin
                    rin_en     = 1'b1;
                    state_next = boundary;
                end
            end
            ST_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                state_next = boundary;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    reg_sel_decode #(.NUM_REGS(NUM_REGS)) u_out_sel (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (reg_out)
    );

    reg_sel_decode #(.NUM_REGS(NUM_REGS)) u_in_sel (
        .idx    (ra),
        .en     (rin_en),
        .onehot (reg_in)
    );

`ifdef SEQ_PERF_CNT_EN
    logic count_evt;

    // Count only instructions that retire normally; illegal and halt are excluded.
    assign count_evt = ((state == ST_T2) && (cls == CLS_NOP)) ||
                       ((state == ST_T5) && (cls != CLS_MULDIV)) ||
                       (state == ST_T6);

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            instr_count <= '0;
        end else if (count_evt) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Table-driven bench for ctrl_sequencer with hand-written reset/halt sequences.
module tb_ctrl_sequencer;

    logic        Clock, Clear, run, mem_rdy;
    logic [31:0] IR;
    logic        PCout, MDRout, Zhighout, Zlowout, PCin, IncPC, MARin, MDRin;
    logic        IRin, Yin, Read, ZHighIn, ZLowIn, HIin, LOin, halted, illegal;
    logic [4:0]  alu_op;
    logic [15:0] reg_out, reg_in;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] instr_count;
`endif

    ctrl_sequencer #(.ALU_OP_W(5), .NUM_REGS(16), .IR_W(32)) dut (
        .Clock(Clock), .Clear(Clear), .run(run), .mem_rdy(mem_rdy), .IR(IR),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Read(Read), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .HIin(HIin), .LOin(LOin), .alu_op(alu_op), .reg_out(reg_out),
        .reg_in(reg_in), .halted(halted),
`ifdef SEQ_PERF_CNT_EN
        .instr_count(instr_count),
`endif
        .illegal(illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [16:0] B_PCOUT = 17'h10000, B_MDROUT = 17'h08000,
        B_ZHOUT = 17'h04000, B_ZLOUT = 17'h02000, B_PCIN = 17'h01000,
        B_INCPC = 17'h00800, B_MARIN = 17'h00400, B_MDRIN = 17'h00200,
        B_IRIN = 17'h00100, B_YIN = 17'h00080, B_READ = 17'h00040,
        B_ZHIN = 17'h00020, B_ZLIN = 17'h00010, B_HIIN = 17'h00008,
        B_LOIN = 17'h00004, B_HALT = 17'h00002, B_ILL = 17'h00001;
    localparam logic [16:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_PCIN;
    localparam logic [16:0] E_T1 = B_READ | B_MDRIN;
    localparam logic [16:0] E_T2 = B_MDROUT | B_IRIN;

    localparam logic [31:0] IR_AND  = 32'h28918000;
    localparam logic [31:0] IR_DIV  = 32'h80228000;
    localparam logic [31:0] IR_NOT  = 32'h93380000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_ILL  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    typedef struct packed {
        logic        run;
        logic        rdy;
        logic [31:0] ir;
        logic [16:0] strb;
        logic [4:0]  alu;
        logic [15:0] rout;
        logic [15:0] rin;
    } vec_t;

    vec_t        vecs[$];
    logic [16:0] strb;
    int          n_checks = 0;
    int          n_err = 0;

    assign strb = {PCout, MDRout, Zhighout, Zlowout, PCin, IncPC, MARin, MDRin,
                   IRin, Yin, Read, ZHighIn, ZLowIn, HIin, LOin, halted, illegal};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic m, input logic [31:0] ir,
                       input logic [16:0] s, input logic [4:0] a,
                       input logic [15:0] ro, input logic [15:0] ri);
        vecs.push_back({r, m, ir, s, a, ro, ri});
    endtask

    initial begin
        // and R1,R2,R3
        add(0, 1, IR_AND, 17'h0, 5'h00, 16'h0000, 16'h0000);            // IDLE, run=0
        add(1, 1, IR_AND, 17'h0, 5'h00, 16'h0000, 16'h0000);            // IDLE -> T0
        add(1, 1, IR_AND, E_T0, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_AND, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_AND, E_T2, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_AND, B_YIN, 5'h00, 16'h0004, 16'h0000);
        add(1, 1, IR_AND, B_ZLIN, 5'b00101, 16'h0008, 16'h0000);
        add(1, 1, IR_AND, B_ZLOUT, 5'h00, 16'h0000, 16'h0002);
        // div R4,R5 with three wait cycles in T1
        add(1, 0, IR_DIV, E_T0, 5'h00, 16'h0000, 16'h0000);
        add(1, 0, IR_DIV, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(1, 0, IR_DIV, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(1, 0, IR_DIV, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_DIV, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_DIV, E_T2, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_DIV, B_YIN, 5'h00, 16'h0010, 16'h0000);
        add(1, 1, IR_DIV, B_ZLIN | B_ZHIN, 5'b10000, 16'h0020, 16'h0000);
        add(1, 1, IR_DIV, B_ZLOUT | B_LOIN, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_DIV, B_ZHOUT | B_HIIN, 5'h00, 16'h0000, 16'h0000);
        // not R6,R7 (unary skips T3), run drops in T5
        add(1, 1, IR_NOT, E_T0, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_NOT, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_NOT, E_T2, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_NOT, B_ZLIN, 5'b10010, 16'h0080, 16'h0000);
        add(0, 1, IR_NOT, B_ZLOUT, 5'h00, 16'h0000, 16'h0040);
        add(0, 1, IR_NOT, 17'h0, 5'h00, 16'h0000, 16'h0000);            // IDLE
        // nop
        add(1, 1, IR_NOP, 17'h0, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_NOP, E_T0, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_NOP, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_NOP, E_T2, 5'h00, 16'h0000, 16'h0000);
        // illegal opcode
        add(1, 1, IR_ILL, E_T0, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_ILL, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_ILL, E_T2 | B_ILL, 5'h00, 16'h0000, 16'h0000);
        // nop with run low from its T0: completes, then IDLE
        add(0, 1, IR_NOP, E_T0, 5'h00, 16'h0000, 16'h0000);
        add(0, 1, IR_NOP, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(0, 1, IR_NOP, E_T2, 5'h00, 16'h0000, 16'h0000);
        add(0, 1, IR_NOP, 17'h0, 5'h00, 16'h0000, 16'h0000);
        // halt
        add(1, 1, IR_HALT, 17'h0, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_HALT, E_T0, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_HALT, E_T1, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_HALT, E_T2, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_HALT, B_HALT, 5'h00, 16'h0000, 16'h0000);
        add(1, 1, IR_HALT, B_HALT, 5'h00, 16'h0000, 16'h0000);

        Clear = 1'b1; run = 1'b0; mem_rdy = 1'b0; IR = '0;
        #3;
        check("reset_strobes", {15'h0, strb}, 32'h0);
        check("reset_regsel", {reg_out, reg_in}, 32'h0);
        check("reset_alu_op", {27'h0, alu_op}, 32'h0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Clear = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run = vecs[i].run; mem_rdy = vecs[i].rdy; IR = vecs[i].ir;
            #1;
            check($sformatf("row%0d_strobes", i), {15'h0, strb}, {15'h0, vecs[i].strb});
            check($sformatf("row%0d_alu_op", i), {27'h0, alu_op}, {27'h0, vecs[i].alu});
            check($sformatf("row%0d_reg_out", i), {16'h0, reg_out}, {16'h0, vecs[i].rout});
            check($sformatf("row%0d_reg_in", i), {16'h0, reg_in}, {16'h0, vecs[i].rin});
            @(negedge Clock);
        end

        // Still halted with run high; only Clear leaves HALT
        #1;
        check("halt_sticky", {31'h0, halted}, 32'h1);
`ifdef SEQ_PERF_CNT_EN
        check("instr_count_total", instr_count, 32'd5);
`endif
        Clear = 1'b1;
        #1;
        check("clear_from_halt", {15'h0, strb}, 32'h0);
`ifdef SEQ_PERF_CNT_EN
        check("instr_count_cleared", instr_count, 32'd0);
`endif
        @(negedge Clock);
        Clear = 1'b0; run = 1'b1; mem_rdy = 1'b1; IR = IR_AND;
        #1;
        check("idle_after_halt", {15'h0, strb}, 32'h0);

        // Walk into T4 of an and, then clear mid-cycle
        repeat (5) @(negedge Clock);
        #1;
        check("reached_t4_alu_op", {27'h0, alu_op}, {27'h0, 5'b00101});
        #1;
        Clear = 1'b1;
        #1;
        check("clear_mid_t4_strobes", {15'h0, strb}, 32'h0);
        check("clear_mid_t4_regsel", {reg_out, reg_in}, 32'h0);
        check("clear_mid_t4_alu_op", {27'h0, alu_op}, 32'h0);
        @(negedge Clock);
        Clear = 1'b0;
        @(posedge Clock);
        #1;
        check("restart_t0", {15'h0, strb}, {15'h0, E_T0});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
